// File: rtl/debounce_sync.sv
// Debouncer for a raw asynchronous input: two-flop synchronizer,
// stability counter and edge pulses, all outputs registered.
module debounce_sync #(
    parameter int   STABLE_CYCLES = 1000,
    parameter int   CNT_W         = 16,
    parameter logic RESET_LEVEL   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    output logic b,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync2_q;
    logic             b_q, b_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q;
    logic             s;

    assign s = sync2_q;

    // Two-flop synchronizer; the only logic that samples a.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
        end else begin
            sync1_q <= a;
            sync2_q <= sync1_q;
        end
    end

    // Qualify a new level: it must differ from b on consecutive cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (s != b_q) begin
                    if (STABLE_CYCLES == 1) begin
                        b_d    = s;
                        rise_d = s;
                        fall_d = ~s;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = COUNT;
                    end
                end
            end
            COUNT: begin
                if (s == b_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    b_d     = s;
                    cnt_d   = '0;
                    rise_d  = s;
                    fall_d  = ~s;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; reset beats any pending update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            b_q     <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= (state_d == COUNT);
        end
    end

    assign b    = b_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: STABLE_CYCLES=4 and =1 instances share
// stimulus; a history-based model predicts every output each cycle.
module tb_debounce_sync;

    localparam logic RL = 1'b1;

    logic clk;
    logic rst_n;
    logic a;
    logic b4, rise4, fall4, busy4;
    logic b1, rise1, fall1, busy1;

    int n_checks;
    int n_err;

    debounce_sync #(
        .STABLE_CYCLES(4),
        .CNT_W(16),
        .RESET_LEVEL(RL)
    ) u_dut4 (
        .clk(clk),
        .rst_n(rst_n),
        .a(a),
        .b(b4),
        .rise(rise4),
        .fall(fall4),
        .busy(busy4)
    );

    debounce_sync #(
        .STABLE_CYCLES(1),
        .CNT_W(4),
        .RESET_LEVEL(RL)
    ) u_dut1 (
        .clk(clk),
        .rst_n(rst_n),
        .a(a),
        .b(b1),
        .rise(rise1),
        .fall(fall1),
        .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: a delayed by two samples gives s; hist holds recent s.
    int       st[2];
    logic     ms1[2];
    logic     ms2[2];
    logic     mb[2];
    logic     mr[2];
    logic     mf[2];
    logic     mbusy[2];
    logic [7:0] hist[2];
    int       hlen[2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    // b adopts s once s has differed from b on st consecutive samples.
    task automatic model_step(input int i);
        int   n;
        logic s_now;
        if (!rst_n) begin
            ms1[i]   = RL;
            ms2[i]   = RL;
            mb[i]    = RL;
            mr[i]    = 1'b0;
            mf[i]    = 1'b0;
            mbusy[i] = 1'b0;
            hlen[i]  = 0;
            hist[i]  = '0;
        end else begin
            s_now   = ms2[i];
            hist[i] = {hist[i][6:0], s_now};
            if (hlen[i] < 8) hlen[i]++;
            n = 0;
            for (int k = 0; k < hlen[i]; k++) begin
                if (hist[i][k] == mb[i]) break;
                n++;
            end
            if (n >= st[i]) begin
                mb[i]    = s_now;
                mr[i]    = s_now;
                mf[i]    = ~s_now;
                mbusy[i] = 1'b0;
            end else begin
                mr[i]    = 1'b0;
                mf[i]    = 1'b0;
                mbusy[i] = (n > 0);
            end
            ms2[i] = ms1[i];
            ms1[i] = a;
        end
    endtask

    task automatic cyc(input logic av, input logic rv);
        a     = av;
        rst_n = rv;
        @(posedge clk);
        #1;
        model_step(0);
        model_step(1);
        check("b4",    32'(b4),    32'(mb[0]));
        check("rise4", 32'(rise4), 32'(mr[0]));
        check("fall4", 32'(fall4), 32'(mf[0]));
        check("busy4", 32'(busy4), 32'(mbusy[0]));
        check("b1",    32'(b1),    32'(mb[1]));
        check("rise1", 32'(rise1), 32'(mr[1]));
        check("fall1", 32'(fall1), 32'(mf[1]));
        check("busy1", 32'(busy1), 32'(mbusy[1]));
        check("excl4", 32'(rise4 & fall4), 32'd0);
        check("excl1", 32'(rise1 & fall1), 32'd0);
    endtask

    task automatic hold(input logic av, input int n);
        for (int k = 0; k < n; k++) cyc(av, 1'b1);
    endtask

    int fall_cnt;

    initial begin
        n_checks = 0;
        n_err    = 0;
        st[0]    = 4;
        st[1]    = 1;
        a        = 1'b0;
        rst_n    = 1'b0;

        // Reset held with a=0: outputs pinned to reset values.
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0);
        check("rst_b4", 32'(b4), 32'd1);
        check("rst_busy4", 32'(busy4), 32'd0);

        // Return to idle level, then a clean press.
        hold(1'b1, 8);
        fall_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b1);
            if (k == 2) check("press_busy", 32'(busy4), 32'd1);
            if (k == 4) check("press_b_early", 32'(b4), 32'd1);
            if (k == 5) check("press_b", 32'(b4), 32'd0);
            fall_cnt += int'(fall4);
        end
        check("press_falls", 32'(fall_cnt), 32'd1);

        // Clean release.
        hold(1'b1, 10);
        check("release_b", 32'(b4), 32'd1);

        // Bounce: never stable long enough for the 4-cycle filter.
        hold(1'b0, 3);
        hold(1'b1, 1);
        hold(1'b0, 2);
        hold(1'b1, 8);
        check("bounce_b", 32'(b4), 32'd1);

        // Reset in the middle of qualification.
        hold(1'b0, 4);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("midrst_busy", 32'(busy4), 32'd0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b1);
            if (k == 4) check("midrst_b_early", 32'(b4), 32'd1);
            if (k == 5) check("midrst_fall", 32'(fall4), 32'd1);
        end

        // Randomized bouncy input with occasional resets.
        for (int k = 0; k < 600; k++) begin
            logic lv;
            int   len;
            lv  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 9))
                                              : int'($urandom_range(1, 4));
            if ($urandom_range(0, 49) == 0) begin
                cyc(lv, 1'b0);
                len = len - 1;
            end
            hold(lv, len);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
